misr_compactor: RTL and testbench
=================================

Name: misr_compactor

Overview:
- Parametrised successor to the fixed 16-bit BIST MISR.
- Compacts an IN_W-bit response vector per enabled cycle into a SIG_W-bit signature using a true polynomial-feedback MISR.
- Counts compacted patterns and ends the session automatically after PATTERNS updates, then compares against a golden value.
- Supports serial unload of the signature to the scan/debug port; sits between the CUT response taps and the BIST controller.

Parameters:
- SIG_W, 16, signature width; must be >= 2.
- IN_W, 10, response vector width; must be >= 1 and <= SIG_W.
- POLY, 16'h1021, feedback taps; bit i set means MSB feedback XORs into stage i. Bit 0 must be 1.
- PATTERNS, 1024, number of enabled cycles per session; must be >= 1.
- GOLDEN, 16'h0000, expected final signature, SIG_W bits.

Ports:
- clock, input, 1, sole clock; all logic on the rising edge.
- reset, input, 1, synchronous active-high reset.
- init, input, 1, start or restart a session.
- enable, input, 1, compact data_in this cycle (RUN only).
- data_in, input, IN_W, response vector.
- unload, input, 1, request serial readout (DONE only).
- signature, output, SIG_W, current MISR register.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE and UNLOAD.
- pass_nfail, output, 1, registered compare result.
- sig_serial, output, 1, serial readout bit.
- sig_serial_valid, output, 1, sig_serial qualifier.

Behaviour:
- Reset values: all outputs 0; state IDLE; pattern count 0; unload bit count 0.
- States:
  - IDLE: waits for init.
  - RUN: compaction.
  - DONE: result held.
  - UNLOAD: shifting out the signature.
- Transitions:
  - init in any state: signature <= 0, count <= 0, pass_nfail <= 0, go to RUN next cycle. The init cycle performs no compaction.
  - init has priority over enable and unload; reset has priority over everything.
- MISR update (RUN and enable), with m = signature[SIG_W-1] and d = data_in zero-extended to SIG_W:
  - next[0] = m ^ d[0]
  - next[i] = signature[i-1] ^ (POLY[i] & m) ^ d[i], for i = 1..SIG_W-1
- Pattern count:
  - Increments on each update; width $clog2(PATTERNS+1).
  - The update that makes count == PATTERNS also moves the state to DONE. done rises the cycle after the final update.
  - On DONE entry, pass_nfail <= (next signature == GOLDEN). It is held through DONE and UNLOAD, and cleared by init or reset.
- enable outside RUN is ignored: signature holds, no count change.
- RUN with enable low: signature and count hold indefinitely; no timeout.
- unload in DONE: go to UNLOAD for exactly SIG_W cycles.
  - Each cycle: sig_serial = signature[0], sig_serial_valid = 1, then signature rotates right by one (bit 0 into MSB).
  - After SIG_W shifts the signature is restored bit-exact; return to DONE with sig_serial_valid = 0.
  - unload during UNLOAD or in other states is ignored.
- init during UNLOAD aborts the unload: sig_serial_valid drops the next cycle and the signature is cleared.
- sig_serial and sig_serial_valid are registered outputs: valid follows the UNLOAD state one-for-one, and sig_serial is 0 when valid is low.
- Elaboration-time checks:
  - IN_W > SIG_W is an error.
  - POLY[0] == 0 is an error.

Decomposition:
- Shared package bist_pkg:
  - state enum (IDLE, RUN, DONE, UNLOAD)
  - default polynomial constants (CRC16_CCITT = 16'h1021, PRIM32 = 32'h04C11DB7)
- One natural sub-module: misr_core.
  - Purely combinational next-signature function of (signature, data_in, POLY).
  - Reused by future multi-channel compactors.
- FSM, counters and unload shifter live in misr_compactor.

Test Plan:
- Single-bit propagation: PATTERNS=17, GOLDEN=16'h1021; init, then enable with data_in=10'h001 on the first cycle and 0 for 16 cycles. Required: signature 16'h0001 after update 1, 16'h8000 after update 16, 16'h1021 after update 17; done=1 the next cycle; pass_nfail=1.
- All-zero session: PATTERNS=4, GOLDEN=16'h0001; data 0 for 4 enabled cycles. Required: signature 0, done=1, pass_nfail=0.
- Gapped enable: PATTERNS=17 with the same stimulus as the first scenario, but enable low on alternate cycles (data_in=10'h3FF while low). Required: identical final signature 16'h1021; done after the 17th enabled cycle only.
- Unload: from DONE with signature 16'h1021, pulse unload. Required:
  - 16 consecutive cycles of sig_serial_valid=1, with sig_serial = 1,0,0,0,0,1,0,0,0,0,0,0,1,0,0,0 (LSB first);
  - signature equals 16'h1021 afterwards;
  - a second unload in mid-shift is ignored.
- Abort and restart: assert init at unload bit 5, then assert reset in mid-RUN. Required: valid drops next cycle and signature is 0; after reset, all outputs are 0 and the state is IDLE; enable in IDLE leaves signature 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor FSM state encoding and common feedback polynomials.
// No ports.
package bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StUnload
    } bist_state_e;

    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] PRIM32      = 32'h04C11DB7;

endpackage

// File: rtl/misr_core.sv
// Combinational next-state function of a polynomial-feedback MISR.
// Ports:
//   sig_i   - current signature register
//   data_i  - response vector, zero-extended into the low stages
//   next_o  - signature after one compaction step
module misr_core #(
    parameter int unsigned      SIG_W = 16,
    parameter int unsigned      IN_W  = 10,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [SIG_W-1:0] next_o
);

    logic             msb;
    logic [SIG_W-1:0] data_ext;
    logic [SIG_W-1:0] feedback;

    always_comb begin
        msb      = sig_i[SIG_W-1];
        data_ext = SIG_W'(data_i);
        // POLY[0] is required to be 1, so stage 0 receives the MSB through this mask.
        feedback = POLY & {SIG_W{msb}};
        next_o   = {sig_i[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;
    end

endmodule

// File: rtl/misr_compactor.sv
// Session-controlled MISR response compactor with golden compare and serial unload.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   init               - start/restart a session (clears signature, count, result)
//   enable, data_in    - compact data_in this cycle while running
//   unload             - request LSB-first serial readout while done
//   signature          - current MISR register
//   busy, done         - session running / session finished (incl. unload)
//   pass_nfail         - final signature matched GOLDEN
//   sig_serial(_valid) - registered serial readout bit and its qualifier
module misr_compactor
    import bist_pkg::*;
#(
    parameter int unsigned      SIG_W    = 16,
    parameter int unsigned      IN_W     = 10,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(CRC16_CCITT),
    parameter int unsigned      PATTERNS = 1024,
    parameter logic [SIG_W-1:0] GOLDEN   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init,
    input  logic             enable,
    input  logic [IN_W-1:0]  data_in,
    input  logic             unload,
    output logic [SIG_W-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass_nfail,
    output logic             sig_serial,
    output logic             sig_serial_valid
);

    localparam int unsigned CntW = $clog2(PATTERNS + 1);
    localparam int unsigned BitW = $clog2(SIG_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(PATTERNS);
    localparam logic [BitW-1:0] BitLast = BitW'(SIG_W);

    if (SIG_W < 2) begin : g_bad_sig_w
        $error("misr_compactor: SIG_W must be at least 2");
    end
    if (IN_W < 1 || IN_W > SIG_W) begin : g_bad_in_w
        $error("misr_compactor: IN_W must be in 1..SIG_W");
    end
    if (POLY[0] == 1'b0) begin : g_bad_poly
        $error("misr_compactor: POLY[0] must be 1");
    end
    if (PATTERNS < 1) begin : g_bad_patterns
        $error("misr_compactor: PATTERNS must be at least 1");
    end

    bist_state_e      state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_inc;
    logic [BitW-1:0]  bit_q, bit_d;
    logic             pass_q, pass_d;
    logic             ser_q, ser_d;
    logic             val_q, val_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SIG_W-1:0] misr_next;

    misr_core #(
        .SIG_W (SIG_W),
        .IN_W  (IN_W),
        .POLY  (POLY)
    ) u_misr_core (
        .sig_i  (sig_q),
        .data_i (data_in),
        .next_o (misr_next)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pass_d  = pass_q;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        cnt_inc = cnt_q + 1'b1;

        if (init) begin
            state_d = StRun;
            sig_d   = '0;
            cnt_d   = '0;
            bit_d   = '0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StRun: begin
                    if (enable) begin
                        sig_d = misr_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntLast) begin
                            state_d = StDone;
                            pass_d  = (misr_next == GOLDEN);
                        end
                    end
                end
                StDone: begin
                    if (unload) begin
                        // First shift happens on entry, so the UNLOAD state lasts SIG_W cycles.
                        state_d = StUnload;
                        bit_d   = BitW'(1);
                        ser_d   = sig_q[0];
                        val_d   = 1'b1;
                        sig_d   = {sig_q[0], sig_q[SIG_W-1:1]};
                    end
                end
                StUnload: begin
                    if (bit_q == BitLast) begin
                        // SIG_W rotations done: signature is back to its original value.
                        state_d = StDone;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        ser_d = sig_q[0];
                        val_d = 1'b1;
                        sig_d = {sig_q[0], sig_q[SIG_W-1:1]};
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone) || (state_d == StUnload);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            sig_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            pass_q  <= 1'b0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pass_q  <= pass_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign signature        = sig_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_nfail       = pass_q;
    assign sig_serial       = ser_q;
    assign sig_serial_valid = val_q;

endmodule

// File: tb/tb_misr_compactor.sv
module tb_misr_compactor;

    localparam logic [15:0] POLY = 16'h1021;
    localparam int PAT0 = 17;
    localparam int PAT1 = 4;
    localparam logic [15:0] GOLD0 = 16'h1021;
    localparam logic [15:0] GOLD1 = 16'h0001;

    logic        clock = 1'b0;
    logic [1:0]  reset_v = 2'b11;
    logic [1:0]  init_v = 2'b00;
    logic [1:0]  enable_v = 2'b00;
    logic [1:0]  unload_v = 2'b00;
    logic [9:0]  din_v [2];
    logic [15:0] sig_w [2];
    logic [1:0]  busy_w, done_w, pass_w, ser_w, val_w;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    misr_compactor #(
        .SIG_W(16), .IN_W(10), .POLY(POLY), .PATTERNS(PAT0), .GOLDEN(GOLD0)
    ) dut0 (
        .clock(clock), .reset(reset_v[0]), .init(init_v[0]), .enable(enable_v[0]),
        .data_in(din_v[0]), .unload(unload_v[0]), .signature(sig_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass_nfail(pass_w[0]), .sig_serial(ser_w[0]),
        .sig_serial_valid(val_w[0])
    );

    misr_compactor #(
        .SIG_W(16), .IN_W(10), .POLY(POLY), .PATTERNS(PAT1), .GOLDEN(GOLD1)
    ) dut1 (
        .clock(clock), .reset(reset_v[1]), .init(init_v[1]), .enable(enable_v[1]),
        .data_in(din_v[1]), .unload(unload_v[1]), .signature(sig_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass_nfail(pass_w[1]), .sig_serial(ser_w[1]),
        .sig_serial_valid(val_w[1])
    );

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 run, 2 done, 3 unloading.
    int          m_mode [2];
    int          m_cnt  [2];
    int          m_pos  [2];
    logic [15:0] m_sig  [2];
    logic [15:0] m_word [2];
    logic        m_pass [2];
    logic        m_ser  [2];
    logic        m_val  [2];

    // Signature as a polynomial: multiply by x modulo x^16 + POLY, then add the data.
    function automatic logic [15:0] poly_step(input logic [15:0] s, input logic [9:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ {1'b1, POLY};
        return t[15:0] ^ {6'd0, d};
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] w, input int k);
        int n;
        n = k % 16;
        if (n == 0) return w;
        return (w >> n) | (w << (16 - n));
    endfunction

    task automatic model_step(input int k);
        if (reset_v[k]) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_sig[k] = '0;
            m_pass[k] = 0; m_ser[k] = 0; m_val[k] = 0;
        end else if (init_v[k]) begin
            m_mode[k] = 1; m_cnt[k] = 0; m_sig[k] = '0;
            m_pass[k] = 0; m_ser[k] = 0; m_val[k] = 0;
        end else begin
            m_ser[k] = 0;
            m_val[k] = 0;
            case (m_mode[k])
                1: if (enable_v[k]) begin
                    m_sig[k] = poly_step(m_sig[k], din_v[k]);
                    m_cnt[k]++;
                    if (m_cnt[k] == ((k == 0) ? PAT0 : PAT1)) begin
                        m_mode[k] = 2;
                        m_pass[k] = (m_sig[k] == ((k == 0) ? GOLD0 : GOLD1));
                    end
                end
                2: if (unload_v[k]) begin
                    m_word[k] = m_sig[k];
                    m_pos[k]  = 0;
                    m_mode[k] = 3;
                    m_val[k]  = 1;
                    m_ser[k]  = m_word[k][0];
                    m_sig[k]  = rotr(m_word[k], 1);
                end
                3: if (m_pos[k] == 15) begin
                    m_mode[k] = 2;
                    m_sig[k]  = m_word[k];
                end else begin
                    m_pos[k]++;
                    m_val[k] = 1;
                    m_ser[k] = m_word[k][m_pos[k]];
                    m_sig[k] = rotr(m_word[k], m_pos[k] + 1);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_pos[k] = 0; m_sig[k] = '0; m_word[k] = '0;
            m_pass[k] = 0; m_ser[k] = 0; m_val[k] = 0;
            din_v[k] = '0;
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("signature", k, {16'd0, sig_w[k]}, {16'd0, m_sig[k]});
                check("busy", k, {31'd0, busy_w[k]}, {31'd0, m_mode[k] == 1});
                check("done", k, {31'd0, done_w[k]}, {31'd0, m_mode[k] >= 2});
                check("pass_nfail", k, {31'd0, pass_w[k]}, {31'd0, m_pass[k]});
                check("sig_serial", k, {31'd0, ser_w[k]}, {31'd0, m_ser[k]});
                check("sig_serial_valid", k, {31'd0, val_w[k]}, {31'd0, m_val[k]});
            end
        end
    end

    // Advance one clock; inputs change shortly after the rising edge.
    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] exp_word;

    initial begin
        exp_word = 16'h1021;
        cycle();
        chk_en = 1'b1;
        cycle();
        reset_v = 2'b00;
        check("reset_sig", 0, {16'd0, sig_w[0]}, 32'h0);
        check("reset_busy", 0, {31'd0, busy_w[0]}, 32'h0);
        check("reset_done", 0, {31'd0, done_w[0]}, 32'h0);
        check("reset_valid", 1, {31'd0, val_w[1]}, 32'h0);

        // Single-bit propagation.
        init_v[0] = 1'b1;
        cycle();
        init_v[0] = 1'b0;
        check("init_busy", 0, {31'd0, busy_w[0]}, 32'h1);
        enable_v[0] = 1'b1;
        din_v[0] = 10'h001;
        cycle();
        check("upd1_sig", 0, {16'd0, sig_w[0]}, 32'h0001);
        din_v[0] = 10'h000;
        for (int i = 0; i < 15; i++) cycle();
        check("upd16_sig", 0, {16'd0, sig_w[0]}, 32'h8000);
        check("upd16_done", 0, {31'd0, done_w[0]}, 32'h0);
        cycle();
        enable_v[0] = 1'b0;
        check("upd17_sig", 0, {16'd0, sig_w[0]}, 32'h1021);
        check("upd17_done", 0, {31'd0, done_w[0]}, 32'h1);
        check("upd17_pass", 0, {31'd0, pass_w[0]}, 32'h1);
        cycle();

        // All-zero session on the short instance.
        init_v[1] = 1'b1;
        cycle();
        init_v[1] = 1'b0;
        enable_v[1] = 1'b1;
        din_v[1] = 10'h000;
        for (int i = 0; i < 4; i++) cycle();
        enable_v[1] = 1'b0;
        check("zero_sig", 1, {16'd0, sig_w[1]}, 32'h0);
        check("zero_done", 1, {31'd0, done_w[1]}, 32'h1);
        check("zero_pass", 1, {31'd0, pass_w[1]}, 32'h0);

        // Gapped enable: same data, idle cycles carry junk data.
        init_v[0] = 1'b1;
        cycle();
        init_v[0] = 1'b0;
        for (int i = 0; i < 17; i++) begin
            enable_v[0] = 1'b1;
            din_v[0] = (i == 0) ? 10'h001 : 10'h000;
            cycle();
            check("gap_done", 0, {31'd0, done_w[0]}, {31'd0, i == 16});
            if (i < 16) begin
                enable_v[0] = 1'b0;
                din_v[0] = 10'h3FF;
                cycle();
                check("gap_hold_done", 0, {31'd0, done_w[0]}, 32'h0);
            end
        end
        enable_v[0] = 1'b0;
        din_v[0] = 10'h000;
        check("gap_sig", 0, {16'd0, sig_w[0]}, 32'h1021);

        // Unload with a redundant request mid-shift.
        unload_v[0] = 1'b1;
        cycle();
        for (int b = 0; b < 16; b++) begin
            check("unload_valid", 0, {31'd0, val_w[0]}, 32'h1);
            check("unload_bit", 0, {31'd0, ser_w[0]}, {31'd0, exp_word[b]});
            unload_v[0] = (b == 3);
            cycle();
        end
        unload_v[0] = 1'b0;
        check("unload_end_valid", 0, {31'd0, val_w[0]}, 32'h0);
        check("unload_end_sig", 0, {16'd0, sig_w[0]}, 32'h1021);
        check("unload_end_done", 0, {31'd0, done_w[0]}, 32'h1);

        // Abort the unload at bit 5, then reset in the middle of a run.
        unload_v[0] = 1'b1;
        cycle();
        unload_v[0] = 1'b0;
        for (int b = 0; b < 5; b++) cycle();
        check("abort_bit5", 0, {31'd0, ser_w[0]}, {31'd0, exp_word[5]});
        init_v[0] = 1'b1;
        cycle();
        init_v[0] = 1'b0;
        check("abort_valid", 0, {31'd0, val_w[0]}, 32'h0);
        check("abort_sig", 0, {16'd0, sig_w[0]}, 32'h0);
        enable_v[0] = 1'b1;
        din_v[0] = 10'h3FF;
        for (int i = 0; i < 3; i++) cycle();
        reset_v[0] = 1'b1;
        cycle();
        reset_v[0] = 1'b0;
        check("rst_sig", 0, {16'd0, sig_w[0]}, 32'h0);
        check("rst_busy", 0, {31'd0, busy_w[0]}, 32'h0);
        check("rst_pass", 0, {31'd0, pass_w[0]}, 32'h0);
        for (int i = 0; i < 3; i++) cycle();
        enable_v[0] = 1'b0;
        check("idle_sig", 0, {16'd0, sig_w[0]}, 32'h0);
        check("idle_busy", 0, {31'd0, busy_w[0]}, 32'h0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
